// File: rtl/uart_pkg.sv
// Shared types and helpers for the UART receive path: FSM states, parity modes
// and the expected-parity function.
package uart_pkg;

    typedef enum logic [2:0] {
        S_IDLE,
        S_START,
        S_DATA,
        S_PARITY,
        S_STOP
    } uart_state_e;

    localparam int PARITY_NONE  = 0;
    localparam int PARITY_ODD   = 1;
    localparam int PARITY_EVEN  = 2;
    localparam int PARITY_MARK  = 3;
    localparam int PARITY_SPACE = 4;

    // Value the parity bit must carry for a given (zero-extended) data word.
    function automatic logic expected_parity(input logic [7:0] data, input int mode);
        case (mode)
            PARITY_ODD:  return ~(^data);
            PARITY_EVEN: return ^data;
            PARITY_MARK: return 1'b1;
            default:     return 1'b0;
        endcase
    endfunction

endpackage

// File: rtl/uart_sync.sv
// Reset-valued flop chain used to bring an asynchronous serial line into the
// clk domain; shared between the receive and transmit sides.
module uart_sync #(
    parameter int   SYNC_DEPTH = 3,
    parameter logic RESET_VAL  = 1'b1
) (
    input  logic clk,
    input  logic rst,
    input  logic d,
    output logic q
);

    logic [SYNC_DEPTH-1:0] chain_reg;

    always_ff @(posedge clk) begin
        if (rst) chain_reg[0] <= RESET_VAL;
        else     chain_reg[0] <= d;
    end

    generate
        for (genvar gi = 1; gi < SYNC_DEPTH; gi++) begin : g_stage
            always_ff @(posedge clk) begin
                if (rst) chain_reg[gi] <= RESET_VAL;
                else     chain_reg[gi] <= chain_reg[gi-1];
            end
        end
    endgenerate

    assign q = chain_reg[SYNC_DEPTH-1];

endmodule

// File: rtl/uart_receiver.sv
// UART receiver: oversampled start/data/parity/stop deserializer with a
// ready/valid output and error sidebands. Define UART_RX_MAJORITY_EN for 2-of-3 bit voting.
module uart_receiver
    import uart_pkg::*;
#(
    parameter int CLK_HZ     = 12_000_000,
    parameter int BAUDRATE   = 115200,
    parameter int SYNC_DEPTH = 3,
    parameter int DATA_BITS  = 8,
    parameter int PARITY     = 0,
    parameter int STOP_BITS  = 1
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 uart_rx,
    output logic [DATA_BITS-1:0] rx_data,
    output logic                 rx_valid,
    input  logic                 rx_ready,
    output logic                 frame_err,
    output logic                 parity_err,
    output logic                 overrun
);

    localparam int OVERSAMPLE = CLK_HZ / BAUDRATE;
    localparam int CNT_W      = $clog2(OVERSAMPLE);
    localparam int IDX_W      = $clog2(DATA_BITS);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(OVERSAMPLE - 1);
    localparam logic [CNT_W-1:0] CNT_MID  = CNT_W'(OVERSAMPLE / 2);
    localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(DATA_BITS - 1);
    localparam logic             STOP_LAST = 1'(STOP_BITS - 1);

    generate
        if (OVERSAMPLE < 8 || !(DATA_BITS == 7 || DATA_BITS == 8) ||
            !(STOP_BITS == 1 || STOP_BITS == 2) || PARITY < 0 || PARITY > 4 ||
            SYNC_DEPTH < 2) begin : g_bad_cfg
            $error("uart_receiver: unsupported parameter combination");
        end
    endgenerate

    uart_state_e           state_reg, state_next;
    logic [CNT_W-1:0]      cnt_reg;
    logic [IDX_W-1:0]      idx_reg;
    logic                  stop_idx_reg;
    logic [DATA_BITS-1:0]  rx_buf_reg;
    logic                  frame_err_int_reg, parity_err_int_reg;
    logic                  line_seen_reg, commit_reg;
    logic                  rxs, bit_val, sample_tick, wrap_tick;
    logic                  start_frame, store_data, check_parity, check_stop, commit_now;

    uart_sync #(.SYNC_DEPTH(SYNC_DEPTH), .RESET_VAL(1'b1)) u_sync (
        .clk (clk),
        .rst (rst),
        .d   (uart_rx),
        .q   (rxs)
    );

`ifdef UART_RX_MAJORITY_EN
    // Decide one cycle after the centre sample, once all three votes exist.
    logic vote_a_reg, vote_b_reg;
    always_ff @(posedge clk) begin
        if (rst) begin
            vote_a_reg <= 1'b1;
            vote_b_reg <= 1'b1;
        end else begin
            if (cnt_reg == CNT_MID - 1'b1) vote_a_reg <= rxs;
            if (cnt_reg == CNT_MID)        vote_b_reg <= rxs;
        end
    end
    assign bit_val     = (vote_a_reg & vote_b_reg) | (vote_a_reg & rxs) | (vote_b_reg & rxs);
    assign sample_tick = (state_reg != S_IDLE) && (cnt_reg == CNT_MID + 1'b1);
`else
    assign bit_val     = rxs;
    assign sample_tick = (state_reg != S_IDLE) && (cnt_reg == CNT_MID);
`endif

    assign wrap_tick = (state_reg != S_IDLE) && (cnt_reg == CNT_LAST);

    always_ff @(posedge clk) begin
        if (rst) state_reg <= S_IDLE;
        else     state_reg <= state_next;
    end

    always_comb begin
        state_next = state_reg;
        case (state_reg)
            S_IDLE:   if (!rxs && line_seen_reg) state_next = S_START;
            S_START: begin
                if (sample_tick && bit_val) state_next = S_IDLE;
                else if (wrap_tick)         state_next = S_DATA;
            end
            S_DATA: begin
                if (wrap_tick && idx_reg == IDX_LAST)
                    state_next = (PARITY != PARITY_NONE) ? S_PARITY : S_STOP;
            end
            S_PARITY: if (wrap_tick) state_next = S_STOP;
            S_STOP:   if (sample_tick && stop_idx_reg == STOP_LAST) state_next = S_IDLE;
            default:  state_next = S_IDLE;
        endcase
    end

    always_comb begin
        start_frame  = (state_reg == S_IDLE) && !rxs && line_seen_reg;
        store_data   = (state_reg == S_DATA) && sample_tick;
        check_parity = (state_reg == S_PARITY) && sample_tick;
        check_stop   = (state_reg == S_STOP) && sample_tick;
        commit_now   = check_stop && (stop_idx_reg == STOP_LAST);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_reg            <= '0;
            idx_reg            <= '0;
            stop_idx_reg       <= 1'b0;
            rx_buf_reg         <= '0;
            frame_err_int_reg  <= 1'b0;
            parity_err_int_reg <= 1'b0;
            line_seen_reg      <= 1'b1;
            commit_reg         <= 1'b0;
        end else begin
            commit_reg <= commit_now;
            if (state_reg == S_IDLE || wrap_tick) cnt_reg <= '0;
            else                                  cnt_reg <= cnt_reg + 1'b1;
            if (state_reg == S_IDLE && rxs) line_seen_reg <= 1'b1;
            if (start_frame) begin
                idx_reg            <= '0;
                stop_idx_reg       <= 1'b0;
                frame_err_int_reg  <= 1'b0;
                parity_err_int_reg <= 1'b0;
            end
            if (wrap_tick && state_reg == S_DATA) idx_reg <= idx_reg + 1'b1;
            if (wrap_tick && state_reg == S_STOP) stop_idx_reg <= 1'b1;
            if (store_data) rx_buf_reg[idx_reg] <= bit_val;
            if (check_parity)
                parity_err_int_reg <= (bit_val != expected_parity(8'(rx_buf_reg), PARITY));
            if (check_stop && !bit_val) frame_err_int_reg <= 1'b1;
            // A low final stop (e.g. a break) must see the line high before re-arming.
            if (commit_now && !bit_val) line_seen_reg <= 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            rx_data    <= '0;
            rx_valid   <= 1'b0;
            frame_err  <= 1'b0;
            parity_err <= 1'b0;
            overrun    <= 1'b0;
        end else begin
            overrun <= 1'b0;
            if (commit_reg) begin
                if (!rx_valid || rx_ready) begin
                    rx_data    <= rx_buf_reg;
                    frame_err  <= frame_err_int_reg;
                    parity_err <= parity_err_int_reg;
                    rx_valid   <= 1'b1;
                end else begin
                    overrun <= 1'b1;
                end
            end else if (rx_valid && rx_ready) begin
                rx_valid <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_uart_receiver.sv
// Directed bench for uart_receiver: an 8N1 instance and an 8E1 instance, each
// driven on its own serial line at 104 clocks per bit.
module tb_uart_receiver;

    localparam int OS      = 104;
    localparam int LAT_MAX = 9 * OS + OS / 2 + 12;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       tx_line = 1'b1;
    logic       sel_par = 1'b0;
    logic       rx_ready = 1'b1;
    logic       uart_rx, uart_rx_p;
    logic [7:0] rx_data, rx_data_p;
    logic       rx_valid, frame_err, parity_err, overrun;
    logic       rx_valid_p, frame_err_p, parity_err_p, overrun_p;

    int n_tests = 0;
    int n_fail  = 0;
    int cyc     = 0;
    int ov_cnt  = 0;

    typedef struct {
        logic [7:0] d;
        logic       fe;
        logic       pe;
        int         cyc;
    } got_t;
    got_t got_q[$];
    got_t gotp_q[$];

    typedef struct {
        logic [7:0] data;
        bit         par_dut;
        bit         par_bit;
        bit         stop_bit;
        logic [7:0] exp_data;
        bit         exp_fe;
        bit         exp_pe;
    } vec_t;
    vec_t vecs[8];

    assign uart_rx   = sel_par ? 1'b1 : tx_line;
    assign uart_rx_p = sel_par ? tx_line : 1'b1;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    uart_receiver dut (
        .clk        (clk),
        .rst        (rst),
        .uart_rx    (uart_rx),
        .rx_data    (rx_data),
        .rx_valid   (rx_valid),
        .rx_ready   (rx_ready),
        .frame_err  (frame_err),
        .parity_err (parity_err),
        .overrun    (overrun)
    );

    uart_receiver #(.PARITY(2)) dut_par (
        .clk        (clk),
        .rst        (rst),
        .uart_rx    (uart_rx_p),
        .rx_data    (rx_data_p),
        .rx_valid   (rx_valid_p),
        .rx_ready   (rx_ready),
        .frame_err  (frame_err_p),
        .parity_err (parity_err_p),
        .overrun    (overrun_p)
    );

    // Record every handshake (taken at the following rising edge) and overrun pulse.
    always @(negedge clk) begin
        if (!rst) begin
            if (rx_valid && rx_ready)
                got_q.push_back('{d: rx_data, fe: frame_err, pe: parity_err, cyc: cyc});
            if (rx_valid_p && rx_ready)
                gotp_q.push_back('{d: rx_data_p, fe: frame_err_p, pe: parity_err_p, cyc: cyc});
            if (overrun) ov_cnt++;
        end
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end else begin
            $display("[TB] ok   %s = 0x%0h", name, act);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic drive_bit(input logic b);
        tx_line = b;
        tick(OS);
    endtask

    // Flip the line for one clock at the centre sample point of the bit.
    task automatic drive_bit_glitch(input logic b);
        tx_line = b;
        tick(54);
        tx_line = ~b;
        tick(1);
        tx_line = b;
        tick(OS - 55);
    endtask

    task automatic send_frame(input logic [7:0] d, input bit has_par, input bit par_bit,
                              input bit stop_bit);
        drive_bit(1'b0);
        for (int i = 0; i < 8; i++) drive_bit(d[i]);
        if (has_par) drive_bit(par_bit);
        drive_bit(stop_bit);
        tx_line = 1'b1;
    endtask

    task automatic check_one(input string name, input logic [7:0] exp_d, input bit exp_fe,
                             input bit exp_pe, input bit use_par);
        got_t g;
        int   n;
        n = use_par ? gotp_q.size() : got_q.size();
        check({name, "_count"}, n, 1);
        if (n >= 1) begin
            g = use_par ? gotp_q[0] : got_q[0];
            check({name, "_data"}, g.d, exp_d);
            check({name, "_frame_err"}, g.fe, exp_fe);
            check({name, "_parity_err"}, g.pe, exp_pe);
        end
    endtask

    initial begin
        #3_000_000;
        $display("[TB] FAIL watchdog: simulation did not finish, got timeout, expected $finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int c0;
        vecs[0] = '{8'hA5, 0, 0, 1, 8'hA5, 0, 0};
        vecs[1] = '{8'h00, 0, 0, 1, 8'h00, 0, 0};
        vecs[2] = '{8'hFF, 0, 0, 1, 8'hFF, 0, 0};
        vecs[3] = '{8'h3C, 0, 0, 1, 8'h3C, 0, 0};
        vecs[4] = '{8'h03, 1, 0, 1, 8'h03, 0, 0};
        vecs[5] = '{8'h03, 1, 1, 1, 8'h03, 0, 1};
        vecs[6] = '{8'h07, 1, 1, 1, 8'h07, 0, 0};
        vecs[7] = '{8'h55, 0, 0, 0, 8'h55, 1, 0};

        tick(5);
        check("reset_rx_valid", rx_valid, 0);
        check("reset_rx_data", rx_data, 0);
        check("reset_flags", {frame_err, parity_err, overrun}, 0);
        check("reset_par_valid", rx_valid_p, 0);
        rst = 1'b0;
        tick(5);

        for (int i = 0; i < 8; i++) begin
            sel_par = vecs[i].par_dut;
            got_q.delete();
            gotp_q.delete();
            c0 = cyc;
            send_frame(vecs[i].data, vecs[i].par_dut, vecs[i].par_bit, vecs[i].stop_bit);
            tick(OS);
            check_one($sformatf("vec%0d", i), vecs[i].exp_data, vecs[i].exp_fe,
                      vecs[i].exp_pe, vecs[i].par_dut);
            if (i == 0 && got_q.size() > 0)
                check("vec0_latency_ok", (got_q[0].cyc - c0) <= LAT_MAX, 1);
        end
        sel_par = 1'b0;

        // Break: bad stop bit then line held low for three more frames.
        got_q.delete();
        drive_bit(1'b0);
        for (int i = 0; i < 8; i++) drive_bit(((8'h55 >> i) & 8'h01) != 0);
        tx_line = 1'b0;
        tick(31 * OS);
        tx_line = 1'b1;
        tick(2 * OS);
        check_one("break", 8'h55, 1, 0, 0);
        got_q.delete();
        send_frame(8'h12, 0, 0, 1);
        tick(OS);
        check_one("after_break", 8'h12, 0, 0, 0);

        // Overrun: consumer stalled across two back-to-back frames.
        got_q.delete();
        ov_cnt   = 0;
        rx_ready = 1'b0;
        send_frame(8'h11, 0, 0, 1);
        send_frame(8'h22, 0, 0, 1);
        tick(OS);
        check("ovr_valid_held", rx_valid, 1);
        check("ovr_data_held", rx_data, 8'h11);
        check("ovr_pulses", ov_cnt, 1);
        rx_ready = 1'b1;
        tick(4);
        check("ovr_valid_drop", rx_valid, 0);
        tick(2 * OS);
        check_one("ovr_accept", 8'h11, 0, 0, 0);

        // Short glitch in idle is a false start.
        got_q.delete();
        tx_line = 1'b0;
        tick(30);
        tx_line = 1'b1;
        tick(2 * OS);
        check("glitch_no_frames", got_q.size(), 0);
        check("glitch_no_valid", rx_valid, 0);
        send_frame(8'h7E, 0, 0, 1);
        tick(OS);
        check_one("after_glitch", 8'h7E, 0, 0, 0);

        // Reset in the middle of a frame.
        got_q.delete();
        ov_cnt = 0;
        drive_bit(1'b0);
        for (int i = 0; i < 4; i++) drive_bit(1'b1);
        tx_line = 1'b1;
        tick(10);
        rst = 1'b1;
        tick(3);
        rst = 1'b0;
        tick(6 * OS);
        check("midrst_no_frames", got_q.size(), 0);
        send_frame(8'h01, 0, 0, 1);
        tick(OS);
        check_one("after_midrst", 8'h01, 0, 0, 0);
        check("midrst_no_overrun", ov_cnt, 0);

`ifdef UART_RX_MAJORITY_EN
        got_q.delete();
        drive_bit_glitch(1'b0);
        for (int i = 0; i < 8; i++) drive_bit_glitch(((8'h5A >> i) & 8'h01) != 0);
        drive_bit_glitch(1'b1);
        tick(OS);
        check_one("majority", 8'h5A, 0, 0, 0);
`endif

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
